// File: rtl/prbs_checker.sv
// Self-synchronising checker for the x[n] = x[n-1] ^ x[n-2] PRBS stream.
// Optional stuck-at-zero detection is enabled by defining PRBS_CHECKER_ZERO_DET_EN.
module prbs_checker #(
    parameter int LOCK_THRESH   = 8,
    parameter int UNLOCK_THRESH = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             din,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
`ifdef PRBS_CHECKER_ZERO_DET_EN
    ,
    output logic             stuck_zero
`endif
);

    localparam int RUN_W  = $clog2(LOCK_THRESH + 1);
    localparam int MISS_W = $clog2(UNLOCK_THRESH + 1);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [RUN_W-1:0]  RUN_ZERO   = RUN_W'(0);
    localparam logic [RUN_W-1:0]  RUN_ONE    = RUN_W'(1);
    localparam logic [RUN_W-1:0]  RUN_LAST   = RUN_W'(LOCK_THRESH - 1);
    localparam logic [MISS_W-1:0] MISS_ZERO  = MISS_W'(0);
    localparam logic [MISS_W-1:0] MISS_ONE   = MISS_W'(1);
    localparam logic [MISS_W-1:0] MISS_LAST  = MISS_W'(UNLOCK_THRESH - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        sat_inc = (value == CNT_MAX) ? value : value + CNT_ONE;
    endfunction

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              hunt_r;
    logic              hunt_nxt_s;
    logic [RUN_W-1:0]  run_r;
    logic [RUN_W-1:0]  run_nxt_s;
    logic [MISS_W-1:0] miss_r;
    logic [MISS_W-1:0] miss_nxt_s;
    logic              h1_r;
    logic              h0_r;
    logic              h1_nxt_s;
    logic              h0_nxt_s;
    logic              pred_s;
    logic              mismatch_s;
    logic              err_nxt_s;
    logic              err_inc_s;
    logic              bit_inc_s;

    assign pred_s = h1_r ^ h0_r;
`ifdef PRBS_CHECKER_ZERO_DET_EN
    // A 00 history never occurs in a live sequence, so it always counts as a miss.
    assign mismatch_s = (din ^ pred_s) | (~h1_r & ~h0_r);
`else
    assign mismatch_s = din ^ pred_s;
`endif

    // Next-state, history and counter-increment decisions for one valid bit.
    always_comb begin
        state_nxt_s = state_r;
        hunt_nxt_s  = hunt_r;
        run_nxt_s   = run_r;
        miss_nxt_s  = miss_r;
        h1_nxt_s    = h1_r;
        h0_nxt_s    = h0_r;
        err_nxt_s   = 1'b0;
        err_inc_s   = 1'b0;
        bit_inc_s   = 1'b0;
        if (ena) begin
            h1_nxt_s = din;
            h0_nxt_s = h1_r;
            case (state_r)
                ST_HUNT: begin
                    if (hunt_r) begin
                        state_nxt_s = ST_CHECK;
                        hunt_nxt_s  = 1'b0;
                        run_nxt_s   = RUN_ZERO;
                    end else begin
                        hunt_nxt_s  = 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (mismatch_s) begin
                        run_nxt_s = RUN_ZERO;
                    end else if (run_r == RUN_LAST) begin
                        state_nxt_s = ST_LOCKED;
                        run_nxt_s   = RUN_ZERO;
                        miss_nxt_s  = MISS_ZERO;
                    end else begin
                        run_nxt_s = run_r + RUN_ONE;
                    end
                end
                ST_LOCKED: begin
                    bit_inc_s = 1'b1;
                    if (mismatch_s) begin
                        err_nxt_s = 1'b1;
                        err_inc_s = 1'b1;
                        if (miss_r == MISS_LAST) begin
                            state_nxt_s = ST_CHECK;
                            run_nxt_s   = RUN_ZERO;
                            miss_nxt_s  = MISS_ZERO;
                        end else begin
                            miss_nxt_s = miss_r + MISS_ONE;
                        end
                    end else begin
                        miss_nxt_s = MISS_ZERO;
                    end
                end
                default: begin
                    state_nxt_s = ST_HUNT;
                    hunt_nxt_s  = 1'b0;
                    run_nxt_s   = RUN_ZERO;
                    miss_nxt_s  = MISS_ZERO;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM, history and registered outputs; clr only touches the counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_HUNT;
            hunt_r    <= 1'b0;
            run_r     <= RUN_ZERO;
            miss_r    <= MISS_ZERO;
            h1_r      <= 1'b0;
            h0_r      <= 1'b0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_count <= CNT_ZERO;
            bit_count <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            hunt_r  <= hunt_nxt_s;
            run_r   <= run_nxt_s;
            miss_r  <= miss_nxt_s;
            h1_r    <= h1_nxt_s;
            h0_r    <= h0_nxt_s;
            locked  <= (state_nxt_s == ST_LOCKED);
            err     <= err_nxt_s;
            if (clr) begin
                err_count <= CNT_ZERO;
                bit_count <= CNT_ZERO;
            end else begin
                err_count <= err_inc_s ? sat_inc(err_count) : err_count;
                bit_count <= bit_inc_s ? sat_inc(bit_count) : bit_count;
            end
        end
    end

`ifdef PRBS_CHECKER_ZERO_DET_EN
    // Flags a generator stuck at zero once comparisons are active.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stuck_zero <= 1'b0;
        end else begin
            stuck_zero <= (state_nxt_s != ST_HUNT) && !h1_nxt_s && !h0_nxt_s;
        end
    end
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: a behavioural model queues expected outputs
// per driven cycle; scenario tasks add fixed-value checks at the key points.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b0;
    logic        din = 1'b0;
    logic        clr = 1'b0;
    logic        locked, err;
    logic [15:0] err_count, bit_count;
    logic        locked_s4, err_s4;
    logic [3:0]  err_count_s4, bit_count_s4;
`ifdef PRBS_CHECKER_ZERO_DET_EN
    logic        stuck_zero, stuck_zero_s4;
`endif

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk(clk), .rst(rst), .ena(ena), .din(din), .clr(clr),
        .locked(locked), .err(err), .err_count(err_count), .bit_count(bit_count)
`ifdef PRBS_CHECKER_ZERO_DET_EN
        , .stuck_zero(stuck_zero)
`endif
    );

    prbs_checker #(.LOCK_THRESH(8), .UNLOCK_THRESH(4), .CNT_W(4)) dut_s4 (
        .clk(clk), .rst(rst), .ena(ena), .din(din), .clr(clr),
        .locked(locked_s4), .err(err_s4), .err_count(err_count_s4), .bit_count(bit_count_s4)
`ifdef PRBS_CHECKER_ZERO_DET_EN
        , .stuck_zero(stuck_zero_s4)
`endif
    );

    typedef struct {
        logic        lk;
        logic        er;
        logic [15:0] ec;
        logic [15:0] bc;
        logic [3:0]  ec4;
        logic [3:0]  bc4;
        logic        sz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   pidx     = 0;

    // reference model state
    int   m_state, m_hunt, m_run, m_miss, m_errc, m_bitc;
    logic m_h1, m_h0, m_err;

    function automatic logic pat(input int i);
        return (i % 3) != 2;
    endfunction

    task automatic model_reset();
        m_state = 0; m_hunt = 0; m_run = 0; m_miss = 0;
        m_errc = 0; m_bitc = 0; m_h1 = 1'b0; m_h0 = 1'b0; m_err = 1'b0;
        sb.delete();
    endtask

    task automatic model_step(input logic e, input logic d, input logic c);
        logic pred, mis;
        exp_t x;
        m_err = 1'b0;
        if (e) begin
            pred = m_h1 ^ m_h0;
            mis  = (d !== pred);
`ifdef PRBS_CHECKER_ZERO_DET_EN
            if (!m_h1 && !m_h0) mis = 1'b1;
`endif
            case (m_state)
                0: begin
                    m_hunt++;
                    if (m_hunt == 2) begin m_state = 1; m_run = 0; m_hunt = 0; end
                end
                1: begin
                    if (mis) m_run = 0;
                    else begin
                        m_run++;
                        if (m_run == 8) begin m_state = 2; m_miss = 0; end
                    end
                end
                2: begin
                    m_bitc++;
                    if (mis) begin
                        m_err = 1'b1; m_errc++; m_miss++;
                        if (m_miss == 4) begin m_state = 1; m_run = 0; end
                    end else m_miss = 0;
                end
                default: m_state = 0;
            endcase
            m_h0 = m_h1;
            m_h1 = d;
        end
        if (c) begin m_errc = 0; m_bitc = 0; end
        x.lk  = (m_state == 2);
        x.er  = m_err;
        x.ec  = (m_errc > 65535) ? 16'hFFFF : 16'(m_errc);
        x.bc  = (m_bitc > 65535) ? 16'hFFFF : 16'(m_bitc);
        x.ec4 = (m_errc > 15) ? 4'hF : 4'(m_errc);
        x.bc4 = (m_bitc > 15) ? 4'hF : 4'(m_bitc);
        x.sz  = (m_state != 0) && !m_h1 && !m_h0;
        sb.push_back(x);
    endtask

    task automatic step(input logic e, input logic d, input logic c);
        ena = e; din = d; clr = c;
        model_step(e, d, c);
        @(posedge clk);
        #1;
    endtask

    task automatic feed_pat(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b1, pat(pidx), 1'b0);
            pidx++;
        end
    endtask

    task automatic align_flip();
        while ((pidx % 3) != 2) feed_pat(1);
    endtask

    task automatic do_reset();
        rst = 1'b0; ena = 1'b0; din = 1'b0; clr = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        pidx = 0;
    endtask

    // Scoreboard: one expected entry retires per clock edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++; if (locked !== e.lk) $display("FAIL sb_locked got %b exp %b t=%0t", locked, e.lk, $time); else n_pass++;
            n_checks++; if (err !== e.er) $display("FAIL sb_err got %b exp %b t=%0t", err, e.er, $time); else n_pass++;
            n_checks++; if (err_count !== e.ec) $display("FAIL sb_err_count got %0d exp %0d t=%0t", err_count, e.ec, $time); else n_pass++;
            n_checks++; if (bit_count !== e.bc) $display("FAIL sb_bit_count got %0d exp %0d t=%0t", bit_count, e.bc, $time); else n_pass++;
            n_checks++; if (locked_s4 !== e.lk) $display("FAIL sb_locked_s4 got %b exp %b t=%0t", locked_s4, e.lk, $time); else n_pass++;
            n_checks++; if (err_s4 !== e.er) $display("FAIL sb_err_s4 got %b exp %b t=%0t", err_s4, e.er, $time); else n_pass++;
            n_checks++; if (err_count_s4 !== e.ec4) $display("FAIL sb_err_count_s4 got %0d exp %0d t=%0t", err_count_s4, e.ec4, $time); else n_pass++;
            n_checks++; if (bit_count_s4 !== e.bc4) $display("FAIL sb_bit_count_s4 got %0d exp %0d t=%0t", bit_count_s4, e.bc4, $time); else n_pass++;
`ifdef PRBS_CHECKER_ZERO_DET_EN
            n_checks++; if (stuck_zero !== e.sz) $display("FAIL sb_stuck_zero got %b exp %b t=%0t", stuck_zero, e.sz, $time); else n_pass++;
`endif
        end
    end

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (locked !== 1'b0) $display("FAIL reset_locked got %b exp 0", locked); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else n_pass++;
        n_checks++; if (err_count !== 16'd0) $display("FAIL reset_err_count got %0d exp 0", err_count); else n_pass++;
        n_checks++; if (bit_count !== 16'd0) $display("FAIL reset_bit_count got %0d exp 0", bit_count); else n_pass++;
    endtask

    task automatic test_lock();
        for (int i = 1; i <= 10; i++) begin
            feed_pat(1);
            if (i == 9) begin
                n_checks++; if (locked !== 1'b0) $display("FAIL lock_early got %b exp 0", locked); else n_pass++;
            end
        end
        n_checks++; if (locked !== 1'b1) $display("FAIL lock_10th got %b exp 1", locked); else n_pass++;
        n_checks++; if (err_count !== 16'd0) $display("FAIL lock_errs got %0d exp 0", err_count); else n_pass++;
    endtask

    task automatic test_error();
        int   pulses = 0;
        logic stayed = 1'b1;
        step(1'b1, pat(pidx), 1'b1); pidx++;
        align_flip();
        step(1'b1, ~pat(pidx), 1'b0); pidx++;
        if (err === 1'b1) pulses++;
        if (locked !== 1'b1) stayed = 1'b0;
        for (int k = 0; k < 6; k++) begin
            feed_pat(1);
            if (err === 1'b1) pulses++;
            if (locked !== 1'b1) stayed = 1'b0;
        end
        n_checks++; if (pulses != 3) $display("FAIL error_pulses got %0d exp 3", pulses); else n_pass++;
        n_checks++; if (stayed !== 1'b1) $display("FAIL error_stay_locked got %b exp 1", stayed); else n_pass++;
        n_checks++; if (err_count !== 16'd3) $display("FAIL error_count got %0d exp 3", err_count); else n_pass++;
    endtask

    task automatic test_unlock();
        int n = 0;
        step(1'b1, pat(pidx), 1'b1); pidx++;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, ~(m_h1 ^ m_h0), 1'b0);
            if (k == 2) begin
                n_checks++; if (locked !== 1'b1) $display("FAIL unlock_3rd got %b exp 1", locked); else n_pass++;
            end
        end
        n_checks++; if (locked !== 1'b0) $display("FAIL unlock_locked got %b exp 0", locked); else n_pass++;
        n_checks++; if (err_count !== 16'd4) $display("FAIL unlock_errs got %0d exp 4", err_count); else n_pass++;
        while (locked !== 1'b1 && n < 40) begin feed_pat(1); n++; end
        n_checks++; if (locked !== 1'b1) $display("FAIL relock_timeout got %b exp 1", locked); else n_pass++;
        n_checks++; if (n < 8) $display("FAIL relock_bits got %0d exp >=8", n); else n_pass++;
    endtask

    task automatic test_gaps_clear();
        do_reset();
        for (int v = 1; v <= 10; v++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            feed_pat(1);
            if (v == 9) begin
                n_checks++; if (locked !== 1'b0) $display("FAIL gap_early got %b exp 0", locked); else n_pass++;
            end
        end
        n_checks++; if (locked !== 1'b1) $display("FAIL gap_lock got %b exp 1", locked); else n_pass++;
        feed_pat(4);
        align_flip();
        step(1'b1, ~pat(pidx), 1'b1); pidx++;
        n_checks++; if (err !== 1'b1) $display("FAIL clr_err got %b exp 1", err); else n_pass++;
        n_checks++; if (err_count !== 16'd0) $display("FAIL clr_err_count got %0d exp 0", err_count); else n_pass++;
        n_checks++; if (bit_count !== 16'd0) $display("FAIL clr_bit_count got %0d exp 0", bit_count); else n_pass++;
        feed_pat(6);
    endtask

    task automatic test_saturation();
        step(1'b1, pat(pidx), 1'b1); pidx++;
        align_flip();
        for (int f = 0; f < 8; f++) begin
            step(1'b1, ~pat(pidx), 1'b0); pidx++;
            feed_pat(5);
        end
        n_checks++; if (err_count !== 16'd24) $display("FAIL sat_wide got %0d exp 24", err_count); else n_pass++;
        n_checks++; if (err_count_s4 !== 4'd15) $display("FAIL sat_err4 got %0d exp 15", err_count_s4); else n_pass++;
        n_checks++; if (bit_count_s4 !== 4'd15) $display("FAIL sat_bit4 got %0d exp 15", bit_count_s4); else n_pass++;
        n_checks++; if (locked !== 1'b1) $display("FAIL sat_locked got %b exp 1", locked); else n_pass++;
    endtask

    task automatic test_async_reset();
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++; if (locked !== 1'b0) $display("FAIL areset_locked got %b exp 0", locked); else n_pass++;
        n_checks++; if (err_count !== 16'd0) $display("FAIL areset_err_count got %0d exp 0", err_count); else n_pass++;
        n_checks++; if (bit_count !== 16'd0) $display("FAIL areset_bit_count got %0d exp 0", bit_count); else n_pass++;
        n_checks++; if (err_count_s4 !== 4'd0) $display("FAIL areset_err_s4 got %0d exp 0", err_count_s4); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        pidx = 0;
        for (int i = 1; i <= 10; i++) begin
            feed_pat(1);
            if (i == 9) begin
                n_checks++; if (locked !== 1'b0) $display("FAIL relock_early got %b exp 0", locked); else n_pass++;
            end
        end
        n_checks++; if (locked !== 1'b1) $display("FAIL relock_10th got %b exp 1", locked); else n_pass++;
    endtask

    task automatic test_zeros();
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b0, 1'b0);
`ifdef PRBS_CHECKER_ZERO_DET_EN
            n_checks++; if (locked !== 1'b0) $display("FAIL zero_locked i=%0d got %b exp 0", i, locked); else n_pass++;
            n_checks++; if (stuck_zero !== (i >= 2)) $display("FAIL zero_stuck i=%0d got %b exp %b", i, stuck_zero, (i >= 2)); else n_pass++;
`else
            if (i == 9 || i == 10) begin
                n_checks++; if (locked !== (i == 10)) $display("FAIL zero_lock i=%0d got %b exp %b", i, locked, (i == 10)); else n_pass++;
            end
`endif
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock();
        test_error();
        test_unlock();
        test_gaps_clear();
        test_saturation();
        test_async_reset();
        test_zeros();
        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 SHALL have parameter LOCK_THRESH, default 8: consecutive matching bits needed to enter LOCKED.
REQ-002 SHALL have parameter UNLOCK_THRESH, default 4: consecutive mismatching bits in LOCKED that force loss of lock.
REQ-003 SHALL have parameter CNT_W, default 16: width of err_count and bit_count.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port ena, input, 1: din carries a valid stream bit this cycle.
REQ-007 SHALL have port din, input, 1: serial bit from the PRBS generator.
REQ-008 SHALL have port clr, input, 1: synchronous clear of err_count and bit_count.
REQ-009 SHALL have port locked, output, 1: high while the FSM is in LOCKED.
REQ-010 SHALL have port err, output, 1: one-cycle pulse per mismatch counted in LOCKED.
REQ-011 SHALL have port err_count, output, CNT_W: saturating count of mismatches.
REQ-012 SHALL have port bit_count, output, CNT_W: saturating count of bits checked in LOCKED.

Function
REQ-013 SHALL keep a 2-bit history h1 (newest) and h0; on each ena cycle, h1<=din and h0<=h1 in every state (self-synchronising).
REQ-014 SHALL compute the predicted bit as h1 XOR h0, matching generator recurrence x[n] = x[n-1] XOR x[n-2].
REQ-015 SHALL ignore cycles with ena low: no state, history, counter or output change, and err low.
REQ-016 SHALL implement states HUNT, CHECK and LOCKED.
REQ-017 HUNT: SHALL shift in the first 2 valid bits without comparing them, then go to CHECK with run=0.
REQ-018 CHECK: on a match SHALL increment run; when run reaches LOCK_THRESH it SHALL go to LOCKED with miss=0; a mismatch SHALL set run=0.
REQ-019 LOCKED: on a match SHALL set miss=0; on a mismatch SHALL pulse err, increment err_count and increment miss.
REQ-020 LOCKED: when miss reaches UNLOCK_THRESH SHALL go to CHECK with run=0; the bit causing the transition SHALL still be counted as an error.
REQ-021 LOCKED: SHALL increment bit_count on every valid bit, including mismatches.
REQ-022 SHALL update locked and err registered, one cycle after the deciding ena cycle.
REQ-023 SHALL saturate err_count and bit_count at 2^CNT_W-1 with no wrap-around.
REQ-024 SHALL let clr override any increment in the same cycle, giving 0 on the next cycle; clr SHALL NOT affect FSM state or history.
REQ-025 SHALL not count errors in HUNT or CHECK.

Reset
REQ-026 While rst is low, SHALL immediately force state HUNT, h1=h0=0, run=miss=0, locked=0, err=0, err_count=0 and bit_count=0.
REQ-027 Reset asserted mid-lock SHALL discard all sync state; after release, relock SHALL take 2+LOCK_THRESH valid bits.

Configuration
REQ-028 With macro PRBS_CHECKER_ZERO_DET_EN defined: history h1=h0=0 SHALL count as a mismatch regardless of din, because 00 never occurs in a valid sequence (stuck-at-zero generator).
REQ-029 With PRBS_CHECKER_ZERO_DET_EN defined: SHALL add output stuck_zero (1 bit, reset 0), high while history is 00 in CHECK or LOCKED.
REQ-030 Without PRBS_CHECKER_ZERO_DET_EN: history 00 SHALL predict 0 as normal, and port stuck_zero SHALL NOT exist.

Verification
REQ-031 Lock: reset, then feed 1,1,0 repeating with ena=1 -> locked rises 1 cycle after the 10th bit; err_count=0.
REQ-032 Error: after lock, flip 1 bit -> err pulses once per resulting mismatch (up to 3 as history realigns); locked stays 1; err_count equals the err pulse count.
REQ-033 Unlock: after lock, feed 4 consecutive bits that each mismatch the prediction -> err_count=4 and locked falls; resuming 1,1,0 relocks after 8 matches.
REQ-034 Gaps and clear: lock with ena toggling every other cycle -> same lock point in valid bits; pulse clr together with an error -> both counters 0 next cycle.
REQ-035 Saturation and reset: CNT_W=4, 20 errors -> err_count=15; drop rst mid-lock -> all outputs 0 immediately, asynchronously to clk.
REQ-036 Zero-detect (macro on): feed all zeros -> locked never rises and stuck_zero is high from the 3rd bit; macro off -> locked rises after the 10th bit.
